// File: rtl/sce_fet_ctrl.sv
// ---------------------------------------------------------------------------
// sce_fet_ctrl : fetch sequencer for the SCE core.
//
// Owns the program counter, issues one read at a time to instruction memory,
// buffers returned instructions in a 2-entry {instr, pc} queue and presents
// the queue head to decode with a valid/accept handshake. A redirect flushes
// the queue, reloads the PC and discards any response still in flight.
//
// Optional build macro:
//   SCE_FET_PERF_CNT_EN - adds FET_CNT, a saturating count of instructions
//                         accepted by decode.
// ---------------------------------------------------------------------------
module sce_fet_ctrl #(
  parameter int              AW          = 32,
  parameter int              DW          = 32,
  parameter logic [AW-1:0]   BOOT_ADDR   = '0,
  parameter int              INSTR_BYTES = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          HALT,
  input  logic          RDR_VLD,
  input  logic [AW-1:0] RDR_ADDR,
  output logic          MEM_REQ,
  output logic [AW-1:0] MEM_ADDR,
  input  logic          MEM_GNT,
  input  logic          MEM_RVLD,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          FET2DEC_VLD,
  output logic [DW-1:0] FET2DEC_INSTR,
  output logic [AW-1:0] FET2DEC_PC,
  input  logic          DEC2FET_VLD,
  output logic          BUSY
`ifdef SCE_FET_PERF_CNT_EN
  ,
  output logic [31:0]   FET_CNT
`endif
);

  localparam logic [AW-1:0] PC_INC = AW'(INSTR_BYTES);

  // HOLD is the decision point between transactions; DROP waits out a
  // response that was orphaned by a redirect.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic [AW-1:0] r_pend_pc;
  logic [AW-1:0] w_pend_nxt;

  // Queue storage and control
  logic [DW-1:0] r_q_instr [2];
  logic [AW-1:0] r_q_pc    [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;

  logic          w_q_vld;
  logic          w_room;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;

  assign w_q_vld = (r_count != 2'd0);
  assign w_room  = (r_count < 2'd2);
  assign w_pop   = w_q_vld & DEC2FET_VLD;
  // A redirect outranks everything: it empties the queue and suppresses the
  // push of a response that lands in the same cycle.
  assign w_flush = RDR_VLD & (r_state != ST_IDLE);
  assign w_push  = (r_state == ST_WAIT) & MEM_RVLD & ~RDR_VLD;

  // Next-state, next-PC and pending-PC selection
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend_pc;

    // A redirect reloads the PC in every state, IDLE included.
    if (RDR_VLD) w_pc_nxt = RDR_ADDR;

    unique case (r_state)
      ST_IDLE: begin
        if (START) w_state_nxt = ST_HOLD;
      end

      ST_HOLD: begin
        if (!RDR_VLD) begin
          if (w_room && !HALT)        w_state_nxt = ST_REQ;
          else if (HALT && !w_q_vld)  w_state_nxt = ST_IDLE;
        end
      end

      ST_REQ: begin
        // The request is never withdrawn by HALT; only a redirect before the
        // grant may cancel it.
        if (MEM_GNT) begin
          w_pend_nxt = r_pc;
          if (RDR_VLD) begin
            w_state_nxt = ST_DROP;
          end else begin
            w_state_nxt = ST_WAIT;
            w_pc_nxt    = r_pc + PC_INC;
          end
        end else if (RDR_VLD) begin
          w_state_nxt = ST_HOLD;
        end
      end

      ST_WAIT: begin
        if (RDR_VLD)       w_state_nxt = MEM_RVLD ? ST_HOLD : ST_DROP;
        else if (MEM_RVLD) w_state_nxt = ST_HOLD;
      end

      ST_DROP: begin
        if (MEM_RVLD) w_state_nxt = ST_HOLD;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, PC and pending-PC registers
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RST) begin
      r_state   <= ST_IDLE;
      r_pc      <= BOOT_ADDR;
      r_pend_pc <= BOOT_ADDR;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (w_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue entry storage, written on push only
  always_ff @(posedge CLK) begin
    // NOTE: entry storage has no reset; the head outputs are forced to zero while the queue is empty.
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= MEM_RDATA;
      r_q_pc[r_wr_ptr]    <= r_pend_pc;
    end
  end

  assign MEM_REQ       = (r_state == ST_REQ);
  assign MEM_ADDR      = r_pc;
  assign FET2DEC_VLD   = w_q_vld;
  assign FET2DEC_INSTR = w_q_vld ? r_q_instr[r_rd_ptr] : '0;
  assign FET2DEC_PC    = w_q_vld ? r_q_pc[r_rd_ptr]    : '0;
  assign BUSY          = (r_state != ST_IDLE) | w_q_vld;

`ifdef SCE_FET_PERF_CNT_EN
  logic [31:0] r_fet_cnt;

  // Saturating count of decode handshakes; redirects do not touch it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                r_fet_cnt <= '0;
    else if (w_pop && (r_fet_cnt != '1))    r_fet_cnt <= r_fet_cnt + 32'd1;
  end

  assign FET_CNT = r_fet_cnt;
`endif

endmodule

// File: tb/tb_sce_fet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sce_fet_ctrl : self-checking bench for sce_fet_ctrl.
// A transaction-level model (PC, activity flags, a queue of {instr, pc})
// predicts every output each cycle; a small memory model answers grants with
// data derived from the granted address. Directed scenarios pin the model
// with literal expectations, then randomized traffic runs against it.
// ---------------------------------------------------------------------------
module tb_sce_fet_ctrl;

  localparam logic [31:0] BOOT = 32'h0000_0100;

  logic        CLK;
  logic        RST;
  logic        START;
  logic        HALT;
  logic        RDR_VLD;
  logic [31:0] RDR_ADDR;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_GNT;
  logic        MEM_RVLD;
  logic [31:0] MEM_RDATA;
  logic        FET2DEC_VLD;
  logic [31:0] FET2DEC_INSTR;
  logic [31:0] FET2DEC_PC;
  logic        DEC2FET_VLD;
  logic        BUSY;
`ifdef SCE_FET_PERF_CNT_EN
  logic [31:0] FET_CNT;
`endif

  sce_fet_ctrl #(
    .AW(32), .DW(32), .BOOT_ADDR(BOOT), .INSTR_BYTES(4)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .HALT(HALT),
    .RDR_VLD(RDR_VLD), .RDR_ADDR(RDR_ADDR),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_GNT(MEM_GNT),
    .MEM_RVLD(MEM_RVLD), .MEM_RDATA(MEM_RDATA),
    .FET2DEC_VLD(FET2DEC_VLD), .FET2DEC_INSTR(FET2DEC_INSTR),
    .FET2DEC_PC(FET2DEC_PC), .DEC2FET_VLD(DEC2FET_VLD), .BUSY(BUSY)
`ifdef SCE_FET_PERF_CNT_EN
    , .FET_CNT(FET_CNT)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  bit          m_run;   // fetcher active
  bit          m_req;   // request on the bus
  bit          m_wait;  // response expected and wanted
  bit          m_drop;  // response expected and unwanted
  logic [31:0] m_cnt;

  // Memory model state
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_data;
  int          fix_delay;

  logic [31:0] grant_log[$];
  logic [31:0] deliver_log[$];

  // Stimulus knobs (percentages)
  int          p_start, p_gnt, p_dec, p_rdr, p_halt_tgl;
  bit          force_start, force_rdr, halt_lvl;
  logic [31:0] force_addr;
  int          start_cyc, first_req_cyc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic bit roll(input int pct);
    return ($urandom_range(0, 99) < pct);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc   = BOOT;
    m_pend = BOOT;
    m_run  = 0;
    m_req  = 0;
    m_wait = 0;
    m_drop = 0;
    m_cnt  = '0;
  endtask

  task automatic mem_grant(input logic [31:0] addr);
    mem_busy  = 1;
    mem_delay = (fix_delay != 0) ? fix_delay : int'($urandom_range(1, 3));
    mem_data  = data_of(addr);
    grant_log.push_back(addr);
  endtask

  // Apply the rules for one rising edge using the inputs held across it.
  task automatic model_edge();
    int n   = m_q.size();
    bit pop = (n != 0) && DEC2FET_VLD;
    if (pop && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (!m_run) begin
      if (RDR_VLD) m_pc = RDR_ADDR;
      if (START) m_run = 1;
      return;
    end
    if (RDR_VLD) begin
      m_q.delete();
      if (m_req) begin
        m_req = 0;
        if (MEM_GNT) begin
          mem_grant(m_pc);
          m_drop = 1;
        end
      end else if (m_wait) begin
        m_wait = 0;
        m_drop = !MEM_RVLD;
      end else if (m_drop && MEM_RVLD) begin
        m_drop = 0;
      end
      m_pc = RDR_ADDR;
      return;
    end
    if (pop) void'(m_q.pop_front());
    if (m_req) begin
      if (MEM_GNT) begin
        mem_grant(m_pc);
        m_pend = m_pc;
        m_pc   = m_pc + 32'd4;
        m_req  = 0;
        m_wait = 1;
      end
    end else if (m_wait) begin
      if (MEM_RVLD) begin
        m_q.push_back('{instr: data_of(m_pend), pc: m_pend});
        m_wait = 0;
      end
    end else if (m_drop) begin
      if (MEM_RVLD) m_drop = 0;
    end else begin
      if (n < 2 && !HALT)      m_req = 1;
      else if (HALT && n == 0) m_run = 0;
    end
  endtask

  task automatic drive_inputs();
    START = force_start || roll(p_start);
    if (force_start) start_cyc = cyc;
    force_start = 0;
    if (roll(p_halt_tgl)) halt_lvl = !halt_lvl;
    HALT = halt_lvl;
    RDR_VLD = force_rdr || roll(p_rdr);
    if (force_rdr)          RDR_ADDR = force_addr;
    else if (roll(15))      RDR_ADDR = 32'hFFFF_FFF8;
    else                    RDR_ADDR = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    force_rdr = 0;
    MEM_GNT     = roll(p_gnt);
    DEC2FET_VLD = roll(p_dec);
    MEM_RVLD  = 1'b0;
    MEM_RDATA = $urandom;
    if (mem_busy) begin
      mem_delay--;
      if (mem_delay == 0) begin
        MEM_RVLD  = 1'b1;
        MEM_RDATA = mem_data;
        mem_busy  = 0;
      end
    end
  endtask

  task automatic compare();
    check("mem_req",  64'(MEM_REQ),     64'(m_req));
    check("mem_addr", 64'(MEM_ADDR),    64'(m_pc));
    check("f2d_vld",  64'(FET2DEC_VLD), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("f2d_instr", 64'(FET2DEC_INSTR), 64'(m_q[0].instr));
      check("f2d_pc",    64'(FET2DEC_PC),    64'(m_q[0].pc));
    end
    check("busy", 64'(BUSY), 64'(m_run || m_q.size() != 0));
`ifdef SCE_FET_PERF_CNT_EN
    check("fet_cnt", 64'(FET_CNT), 64'(m_cnt));
`endif
    if (FET2DEC_VLD && DEC2FET_VLD) deliver_log.push_back(FET2DEC_PC);
    if (MEM_REQ && first_req_cyc < 0) first_req_cyc = cyc;
  endtask

  // One clock: model the edge, drive next inputs, compare at the falling edge.
  task automatic step();
    @(posedge CLK);
    cyc++;
    if (RST) model_reset();
    else     model_edge();
    #1;
    drive_inputs();
    @(negedge CLK);
    compare();
  endtask

  task automatic quiet();
    p_start = 0; p_gnt = 0; p_dec = 0; p_rdr = 0; p_halt_tgl = 0;
    force_start = 0; force_rdr = 0; halt_lvl = 0; fix_delay = 0;
  endtask

  // Asynchronous reset between edges; outputs must clear at once.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST = 1'b1;
    model_reset();
    #1;
    check("rst_mem_req",  64'(MEM_REQ),       64'd0);
    check("rst_mem_addr", 64'(MEM_ADDR),      64'h100);
    check("rst_f2d_vld",  64'(FET2DEC_VLD),   64'd0);
    check("rst_f2d_inst", 64'(FET2DEC_INSTR), 64'd0);
    check("rst_f2d_pc",   64'(FET2DEC_PC),    64'd0);
    check("rst_busy",     64'(BUSY),          64'd0);
`ifdef SCE_FET_PERF_CNT_EN
    check("rst_fet_cnt",  64'(FET_CNT),       64'd0);
`endif
    quiet();
    repeat (2) step();
    RST = 1'b0;
    // Let any abandoned response arrive while the fetcher is idle.
    repeat (7) step();
    grant_log.delete();
    deliver_log.delete();
    first_req_cyc = -1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 0; HALT = 0; RDR_VLD = 0; RDR_ADDR = '0;
    MEM_GNT = 0; MEM_RVLD = 0; MEM_RDATA = '0; DEC2FET_VLD = 0;
    mem_busy = 0; mem_delay = 0; mem_data = '0;
    start_cyc = 0; first_req_cyc = -1; force_addr = '0;
    quiet();
    model_reset();

    // 1) Streaming fetch: immediate grant, 1-cycle response, decode always ready
    do_reset();
    p_gnt = 100; p_dec = 100; fix_delay = 1; force_start = 1;
    repeat (20) step();
    check("start_to_req", 64'(first_req_cyc - start_cyc), 64'd2);
    check("stream_ngrant", 64'(grant_log.size() >= 3), 64'd1);
    check("stream_addr0", 64'(grant_log[0]), 64'h100);
    check("stream_addr1", 64'(grant_log[1]), 64'h104);
    check("stream_addr2", 64'(grant_log[2]), 64'h108);
    check("stream_pc0", 64'(deliver_log[0]), 64'h100);
    check("stream_pc1", 64'(deliver_log[1]), 64'h104);
    check("stream_pc2", 64'(deliver_log[2]), 64'h108);

    // 2) Decode stalled: queue fills to two and requests stop
    do_reset();
    p_gnt = 100; p_dec = 0; fix_delay = 1; force_start = 1;
    repeat (25) step();
    check("full_ngrant", 64'(grant_log.size()), 64'd2);
    check("full_req",    64'(MEM_REQ),          64'd0);
    check("full_head",   64'(FET2DEC_PC),       64'h100);
    p_dec = 100;
    step();
    p_dec = 0;
    repeat (20) step();
    check("pop1_ngrant", 64'(grant_log.size()), 64'd3);
    check("pop1_head",   64'(FET2DEC_PC),       64'h104);

    // 3) Redirect while waiting: response dropped, queue flushed
    do_reset();
    p_gnt = 100; p_dec = 0; fix_delay = 5; force_start = 1;
    for (int i = 0; i < 60 && !(grant_log.size() == 2 && m_wait); i++) step();
    check("rdr_wait_reached", 64'(grant_log.size() == 2 && m_wait), 64'd1);
    force_rdr = 1; force_addr = 32'h400;
    step();
    step();
    check("rdr_flush_vld", 64'(FET2DEC_VLD), 64'd0);
    p_dec = 100;
    repeat (40) step();
    check("rdr_next_addr", 64'(grant_log[2]),   64'h400);
    check("rdr_first_pc",  64'(deliver_log[0]), 64'h400);

    // 4) Redirect in REQ without grant, then PC wrap-around
    do_reset();
    p_gnt = 0; p_dec = 100; fix_delay = 1; force_start = 1;
    for (int i = 0; i < 20 && !m_req; i++) step();
    check("wrap_req_reached", 64'(m_req), 64'd1);
    force_rdr = 1; force_addr = 32'hFFFF_FFFC;
    step();
    step();
    check("withdraw_req", 64'(MEM_REQ), 64'd0);
    p_gnt = 100;
    step();
    check("reissue_req",  64'(MEM_REQ),  64'd1);
    check("reissue_addr", 64'(MEM_ADDR), 64'hFFFF_FFFC);
    repeat (15) step();
    check("wrap_addr0", 64'(grant_log[0]), 64'hFFFF_FFFC);
    check("wrap_addr1", 64'(grant_log[1]), 64'h0);

    // 5) HALT while requesting: request held until grant, then drain to IDLE
    do_reset();
    p_gnt = 0; p_dec = 0; fix_delay = 1; force_start = 1;
    for (int i = 0; i < 20 && !m_req; i++) step();
    halt_lvl = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halt_req_held", 64'(MEM_REQ), 64'd1);
    end
    p_gnt = 100;
    repeat (10) step();
    check("halt_ngrant", 64'(grant_log.size()), 64'd1);
    check("halt_busy_q", 64'(BUSY),             64'd1);
    check("halt_head",   64'(FET2DEC_PC),       64'h100);
    p_dec = 100;
    repeat (5) step();
    check("halt_idle_busy", 64'(BUSY), 64'd0);
    halt_lvl = 0; force_start = 1;
    repeat (20) step();
    check("resume_addr", 64'(grant_log[1]), 64'h104);

    // 6) Randomized traffic, with one asynchronous reset mid-wait
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      p_start = 5; p_rdr = 3; p_halt_tgl = 3; fix_delay = 0;
      p_gnt = $urandom_range(30, 100);
      p_dec = $urandom_range(20, 100);
      force_start = 1;
      repeat (500) step();
      if (seg == 3) begin
        halt_lvl = 0; force_start = 1; p_rdr = 0;
        for (int i = 0; i < 200 && !m_wait; i++) step();
        check("rand_wait_reached", 64'(m_wait), 64'd1);
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
